// File: rtl/fpu_pkg.sv
// Shared FPU definitions: opcodes, one-hot flag positions and instruction field layout.
// Imported by the decode, EXE and writeback stages.
package fpu_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_MUL = 4'd3;
    localparam logic [3:0] OP_DIV = 4'd4;

    localparam int unsigned FLAG_ADD = 0;
    localparam int unsigned FLAG_SUB = 1;
    localparam int unsigned FLAG_MUL = 2;
    localparam int unsigned FLAG_DIV = 3;
    localparam int unsigned FLAG_W   = 4;

    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 28;
    localparam int unsigned RD_LSB  = 24;
    localparam int unsigned RS1_LSB = 20;
    localparam int unsigned RS2_LSB = 16;

    function automatic logic [FLAG_W-1:0] op_flags(input logic [3:0] opc);
        logic [FLAG_W-1:0] f;
        f = '0;
        case (opc)
            OP_ADD:  f[FLAG_ADD] = 1'b1;
            OP_SUB:  f[FLAG_SUB] = 1'b1;
            OP_MUL:  f[FLAG_MUL] = 1'b1;
            OP_DIV:  f[FLAG_DIV] = 1'b1;
            default: f = '0;
        endcase
        return f;
    endfunction

    function automatic logic op_is_arith(input logic [3:0] opc);
        return (opc >= OP_ADD) && (opc <= OP_DIV);
    endfunction

    function automatic logic op_is_illegal(input logic [3:0] opc);
        return opc > OP_DIV;
    endfunction

endpackage

// File: rtl/fpu_regfile.sv
// FP register file: async-reset array, one write port, two combinational
// read ports that forward a same-cycle write.
module fpu_regfile #(
    parameter int unsigned NREGS  = 16,
    parameter int unsigned RIDX_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [RIDX_W-1:0] wr_idx,
    input  logic [31:0]       wr_data,
    input  logic [RIDX_W-1:0] rd_idx_a,
    output logic [31:0]       rd_data_a,
    input  logic [RIDX_W-1:0] rd_idx_b,
    output logic [31:0]       rd_data_b
);

    logic [31:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_idx] <= wr_data;
        end
    end

    // Forwarding lets a consumer issue in the same cycle its producer writes back.
    always_comb begin
        rd_data_a = regs[rd_idx_a];
        rd_data_b = regs[rd_idx_b];
        if (wr_en && (wr_idx == rd_idx_a)) rd_data_a = wr_data;
        if (wr_en && (wr_idx == rd_idx_b)) rd_data_b = wr_data;
    end

endmodule

// File: rtl/fpu_decode_stage.sv
// FPU decode / operand-fetch stage: decodes instructions, reads operands,
// tracks outstanding destinations and stalls on read-after-write hazards.
module fpu_decode_stage
    import fpu_pkg::*;
#(
    parameter int unsigned NREGS  = 16,
    parameter int unsigned RIDX_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [31:0]       ex_a,
    output logic [31:0]       ex_b,
    output logic [3:0]        ex_flags,
    output logic [RIDX_W-1:0] ex_rd,
    input  logic              wb_en,
    input  logic [RIDX_W-1:0] wb_rd,
    input  logic [31:0]       wb_data,
    output logic              illegal
);

    logic [3:0]        opcode;
    logic [RIDX_W-1:0] rd;
    logic [RIDX_W-1:0] rs1;
    logic [RIDX_W-1:0] rs2;
    logic              is_arith;
    logic              is_illegal;
    logic [3:0]        flags;
    logic              unused_low;

    assign opcode     = in_instr[OPC_MSB:OPC_LSB];
    assign rd         = in_instr[RD_LSB  +: RIDX_W];
    assign rs1        = in_instr[RS1_LSB +: RIDX_W];
    assign rs2        = in_instr[RS2_LSB +: RIDX_W];
    assign unused_low = ^in_instr[15:0];

    assign is_arith   = op_is_arith(opcode);
    assign is_illegal = op_is_illegal(opcode);
    assign flags      = op_flags(opcode);

    logic [NREGS-1:0] sb;
    logic [NREGS-1:0] wb_mask;
    logic [NREGS-1:0] sb_live;
    logic [NREGS-1:0] sb_next;
    logic             hazard;
    logic             out_free;
    logic             accept;
    logic             load;
    logic [31:0]      rd_a;
    logic [31:0]      rd_b;

    // A bit retiring this cycle is already invisible to the hazard check,
    // matching the register-file bypass that supplies its value.
    always_comb begin
        wb_mask = '0;
        if (wb_en) wb_mask[wb_rd] = 1'b1;
        sb_live = sb & ~wb_mask;
    end

    assign hazard   = is_arith && (sb_live[rs1] || sb_live[rs2]);
    assign out_free = !ex_valid || ex_ready;
    assign in_ready = out_free && !hazard;
    assign accept   = in_valid && in_ready;
    assign load     = accept && is_arith;

    // Set after clear so a new producer of the same index stays outstanding.
    always_comb begin
        sb_next = sb_live;
        if (load) sb_next[rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb <= '0;
        end else begin
            sb <= sb_next;
        end
    end

    fpu_regfile #(
        .NREGS  (NREGS),
        .RIDX_W (RIDX_W)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wb_en),
        .wr_idx    (wb_rd),
        .wr_data   (wb_data),
        .rd_idx_a  (rs1),
        .rd_data_a (rd_a),
        .rd_idx_b  (rs2),
        .rd_data_b (rd_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_flags <= '0;
            ex_rd    <= '0;
            illegal  <= 1'b0;
        end else begin
            illegal <= accept && is_illegal;
            if (out_free) begin
                ex_valid <= load;
                if (load) begin
                    ex_a     <= rd_a;
                    ex_b     <= rd_b;
                    ex_flags <= flags;
                    ex_rd    <= rd;
                end
            end
        end
    end

endmodule

// File: tb/tb_fpu_decode_stage.sv
// Scoreboard bench for fpu_decode_stage: a behavioural model predicts handshakes
// and queues expected operations; a negedge monitor compares presented outputs.
module tb_fpu_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [3:0]  ex_flags;
    logic [3:0]  ex_rd;
    logic        wb_en;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;

    fpu_decode_stage #(
        .NREGS  (16),
        .RIDX_W (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_instr (in_instr),
        .ex_valid (ex_valid),
        .ex_ready (ex_ready),
        .ex_a     (ex_a),
        .ex_b     (ex_b),
        .ex_flags (ex_flags),
        .ex_rd    (ex_rd),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  flags;
        logic [3:0]  rd;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;

    logic [31:0] m_reg [16];
    bit          m_pend [16];
    bit          m_valid;
    bit          m_ill;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input int op, input int rd, input int rs1, input int rs2);
        logic [31:0] w;
        w = '0;
        w[31:28] = op[3:0];
        w[27:24] = rd[3:0];
        w[23:20] = rs1[3:0];
        w[19:16] = rs2[3:0];
        w[15:0]  = 16'($urandom);
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_reg[i]  = 32'h0;
            m_pend[i] = 1'b0;
        end
        m_valid = 1'b0;
        m_ill   = 1'b0;
        exp_q.delete();
    endtask

    // Stage readiness derived from the pending set and whether EXE can take a result.
    function automatic bit model_ready();
        int  op;
        int  s1;
        int  s2;
        bit  busy1;
        bit  busy2;
        bit  arith;
        op    = int'(in_instr[31:28]);
        s1    = int'(in_instr[23:20]);
        s2    = int'(in_instr[19:16]);
        arith = (op >= 1) && (op <= 4);
        busy1 = m_pend[s1] && !(wb_en && int'(wb_rd) == s1);
        busy2 = m_pend[s2] && !(wb_en && int'(wb_rd) == s2);
        return (!m_valid || ex_ready) && !(arith && (busy1 || busy2));
    endfunction

    task automatic model_step();
        int   op;
        int   s1;
        int   s2;
        int   d;
        bit   free;
        bit   acc;
        exp_t e;
        op   = int'(in_instr[31:28]);
        d    = int'(in_instr[27:24]);
        s1   = int'(in_instr[23:20]);
        s2   = int'(in_instr[19:16]);
        free = !m_valid || ex_ready;
        acc  = in_valid && model_ready();
        if (acc && op >= 1 && op <= 4) begin
            e.a     = (wb_en && int'(wb_rd) == s1) ? wb_data : m_reg[s1];
            e.b     = (wb_en && int'(wb_rd) == s2) ? wb_data : m_reg[s2];
            e.flags = 4'(1 << (op - 1));
            e.rd    = 4'(d);
            exp_q.push_back(e);
        end
        m_ill = acc && (op >= 5);
        if (free) m_valid = acc && (op >= 1) && (op <= 4);
        if (wb_en) begin
            m_reg[wb_rd]  = wb_data;
            m_pend[wb_rd] = 1'b0;
        end
        if (acc && op >= 1 && op <= 4) m_pend[d] = 1'b1;
    endtask

    // Inputs are applied 2 time units after a rising edge; this checks, then advances one cycle.
    task automatic cycle();
        #1;
        chk("in_ready", {31'b0, in_ready}, {31'b0, model_ready()});
        chk("ex_valid", {31'b0, ex_valid}, {31'b0, m_valid});
        chk("illegal",  {31'b0, illegal},  {31'b0, m_ill});
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic drive(input bit v, input logic [31:0] ins, input bit er,
                         input bit we, input int wr, input logic [31:0] wd);
        in_valid = v;
        in_instr = ins;
        ex_ready = er;
        wb_en    = we;
        wb_rd    = wr[3:0];
        wb_data  = wd;
    endtask

    always @(negedge clk) begin
        if (rst_n && ex_valid) begin
            if (exp_q.size() == 0) begin
                chk("ex_spurious", {31'b0, ex_valid}, 32'h0);
            end else begin
                chk("ex_a",     ex_a,              exp_q[0].a);
                chk("ex_b",     ex_b,              exp_q[0].b);
                chk("ex_flags", {28'b0, ex_flags}, {28'b0, exp_q[0].flags});
                chk("ex_rd",    {28'b0, ex_rd},    {28'b0, exp_q[0].rd});
                if (ex_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int pick;
        int cnt;
        int r;
        int op;
        rst_n = 1'b0;
        drive(0, 32'h0, 1, 0, 0, 32'h0);
        model_reset();
        #3;
        chk("rst_ex_valid", {31'b0, ex_valid}, 32'h0);
        chk("rst_ex_a",     ex_a,              32'h0);
        chk("rst_ex_b",     ex_b,              32'h0);
        chk("rst_ex_flags", {28'b0, ex_flags}, 32'h0);
        chk("rst_ex_rd",    {28'b0, ex_rd},    32'h0);
        chk("rst_illegal",  {31'b0, illegal},  32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Preload and basic ADD
        drive(0, 32'h0, 1, 1, 1, 32'h3F000000); cycle();
        drive(0, 32'h0, 1, 1, 2, 32'h3E800000); cycle();
        drive(1, mk(1, 3, 1, 2), 1, 0, 0, 32'h0); cycle();
        // SUB, MUL, DIV back-to-back
        drive(1, mk(2, 7, 1, 2), 1, 0, 0, 32'h0); cycle();
        drive(1, mk(3, 8, 1, 2), 1, 0, 0, 32'h0); cycle();
        drive(1, mk(4, 9, 1, 2), 1, 0, 0, 32'h0); cycle();
        drive(0, 32'h0, 1, 0, 0, 32'h0); cycle();

        // RAW stall released by writeback with bypass
        drive(1, mk(1, 4, 1, 2), 1, 0, 0, 32'h0); cycle();
        drive(1, mk(3, 6, 4, 2), 1, 0, 0, 32'h0); cycle();
        cycle();
        cycle();
        drive(1, mk(3, 6, 4, 2), 1, 1, 4, 32'h3F400000); cycle();
        drive(0, 32'h0, 1, 0, 0, 32'h0); cycle();

        // Backpressure while a new instruction waits
        drive(1, mk(2, 10, 1, 2), 1, 0, 0, 32'h0); cycle();
        drive(1, mk(4, 11, 2, 1), 0, 0, 0, 32'h0); cycle();
        cycle();
        cycle();
        drive(1, mk(4, 11, 2, 1), 1, 0, 0, 32'h0); cycle();
        drive(0, 32'h0, 1, 0, 0, 32'h0); cycle();

        // NOP and illegal opcode
        drive(1, mk(0, 12, 1, 2), 1, 0, 0, 32'h0); cycle();
        drive(1, mk(7, 13, 1, 2), 1, 0, 0, 32'h0); cycle();
        drive(0, 32'h0, 1, 0, 0, 32'h0); cycle();
        cycle();

        // Asynchronous reset while an operation is held and R3 is pending
        drive(0, 32'h0, 1, 1, 3, 32'h12345678); cycle();
        drive(1, mk(1, 3, 1, 2), 0, 0, 0, 32'h0); cycle();
        drive(0, 32'h0, 0, 0, 0, 32'h0);
        #1;
        chk("pre_rst_ex_valid", {31'b0, ex_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("arst_ex_valid", {31'b0, ex_valid}, 32'h0);
        chk("arst_ex_a",     ex_a,              32'h0);
        chk("arst_ex_flags", {28'b0, ex_flags}, 32'h0);
        chk("arst_ex_rd",    {28'b0, ex_rd},    32'h0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        drive(1, mk(1, 5, 3, 1), 1, 0, 0, 32'h0); cycle();
        drive(0, 32'h0, 1, 0, 0, 32'h0); cycle();

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       op = 1 + (r % 4);
            else if (r == 7) op = 0;
            else             op = $urandom_range(5, 15);
            cnt  = 0;
            pick = $urandom_range(0, 15);
            for (int i = 0; i < 16; i++) begin
                if (m_pend[i]) begin
                    cnt++;
                    if ($urandom_range(0, cnt - 1) == 0) pick = i;
                end
            end
            drive($urandom_range(0, 3) != 0,
                  mk(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)),
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) == 0, pick, $urandom);
            cycle();
        end
        drive(0, 32'h0, 1, 0, 0, 32'h0);
        cycle();
        cycle();
        chk("queue_drained", exp_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpu_decode_stage.md
Name: fpu_decode_stage

Overview:
- Instruction-decode / operand-fetch stage placed directly upstream of the FPU EXE stage.
- Accepts 32-bit FPU instruction words from fetch over a valid/ready handshake.
- Reads two IEEE-754 single-precision operands from a 16-entry FP register file and emits operands A/B plus the one-hot operation flags EXE consumes (bit0 add, bit1 sub, bit2 mul, bit3 div).
- Owns the register-file write port for writeback and a scoreboard that stalls on read-after-write hazards.

Parameters:
- NREGS, 16, number of FP registers (power of two).
- RIDX_W, 4, register index width = log2(NREGS).

Ports:
- clk  in  1  stage clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_instr  in  32  [31:28] opcode, [27:24] rd, [23:20] rs1, [19:16] rs2, [15:0] ignored.
- ex_valid  out  1  output register holds a valid operation.
- ex_ready  in  1  EXE accepts the operation.
- ex_a  out  32  operand A = R[rs1].
- ex_b  out  32  operand B = R[rs2].
- ex_flags  out  4  one-hot op: 0001 add, 0010 sub, 0100 mul, 1000 div.
- ex_rd  out  RIDX_W  destination register, carried to writeback.
- wb_en  in  1  writeback strobe.
- wb_rd  in  RIDX_W  writeback register index.
- wb_data  in  32  writeback value.
- illegal  out  1  one-cycle pulse when an undefined opcode is consumed.

Behaviour:
- Reset, asynchronous on rst_n low:
  - ex_valid=0, ex_a=0, ex_b=0, ex_flags=0000, ex_rd=0, illegal=0.
  - All registers = 32'h0, all scoreboard bits = 0.
  - Reset asserted mid-operation discards the held operation.
- Opcode decode:
  - 1 -> add, 2 -> sub, 3 -> mul, 4 -> div.
  - 0 = NOP: consumed, nothing emitted, scoreboard untouched.
  - 5..15 = illegal: consumed, nothing emitted, illegal=1 on the following cycle.
- Latency: one cycle. An instruction accepted at edge N appears on the ex_* outputs after edge N.
- Output register is skid-free:
  - free = !ex_valid || ex_ready.
  - in_ready = free && !hazard.
  - ex_* hold stable while ex_valid && !ex_ready.
- Hazard:
  - hazard = scoreboard[rs1] || scoreboard[rs2] for arithmetic opcodes only.
  - NOP and illegal opcodes never raise hazard.
  - A pending bit being cleared by wb_en this same cycle does not count as a hazard.
- Scoreboard:
  - Accepting an arithmetic instruction sets bit[rd].
  - wb_en clears bit[wb_rd].
  - Set and clear of the same index in the same cycle: set wins, because the new producer is still outstanding.
- Register file write: registered on wb_en.
- Read bypass:
  - If wb_en and wb_rd==rs1, ex_a takes wb_data; same rule for rs2 and ex_b.
  - rs1==rs2 is legal; both operands take the same value.
- rd equal to rs1 or rs2 is legal. Operands are read before the scoreboard bit is set.
- Accepting while EXE drains (ex_valid && ex_ready && in_valid && in_ready) gives back-to-back throughput of one operation per cycle.
- ex_valid drops to 0 after a handshake cycle with no new accept.

Decomposition:
- Package fpu_pkg holds:
  - Opcode localparams: OP_NOP=0, OP_ADD=1, OP_SUB=2, OP_MUL=3, OP_DIV=4.
  - Flag-bit indices: FLAG_ADD=0 .. FLAG_DIV=3.
  - Instruction field bit positions.
- The same package is shared with EXE and writeback.
- One sub-module, fpu_regfile:
  - Async-reset register array.
  - Two combinational read ports with write-bypass.
  - One write port.
- Scoreboard, decode and handshake logic stay in fpu_decode_stage.

Test Plan:
- Reset, then preload through the writeback port: R1=32'h3F000000 (0.5), R2=32'h3E800000 (0.25). Issue ADD rd=3 rs1=1 rs2=2 -> next cycle ex_valid=1, ex_a=3F000000, ex_b=3E800000, ex_flags=0001, ex_rd=3.
- SUB, MUL, DIV on R1,R2 back-to-back with ex_ready=1 -> three consecutive cycles with flags 0010, 0100, 1000 and in_ready held 1.
- RAW stall: ADD rd=4, then MUL rs1=4 -> in_ready=0 until wb_en wb_rd=4 wb_data=32'h3F400000. In that cycle in_ready=1 and the next cycle shows ex_a=3F400000 through the bypass.
- Backpressure: ex_ready=0 for 3 cycles while ex_valid=1 -> ex_a/ex_b/ex_flags/ex_rd unchanged and in_ready=0. Releasing ex_ready accepts the pending instruction on that edge.
- Opcodes 0 and 7 presented -> both consumed. Opcode 0 gives no output and no pulse; opcode 7 gives illegal=1 for exactly one cycle, ex_valid stays 0, scoreboard unchanged.
- Assert rst_n=0 asynchronously while ex_valid=1 and scoreboard[3]=1 -> outputs and scoreboard clear immediately without a clock edge. After release, reading R1 returns 0.
